// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: 65C02 reset/NMI/BRK/IRQ entry sequencer.
// Synchronises NMIB/IRQB, latches NMI edges, arbitrates at instruction
// boundaries and steps the datapath through the 7-cycle entry sequence
// (two internal cycles, PCH/PCL/P pushes, two vector reads). Owns VPB.
// Optional feature macro: INT_SEQ_WAI_EN adds the WAI halt state with
// wake-up on interrupt; without it wai is ignored and waiting/wake stay 0.
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        PHI2,
    input  logic        RES,
    input  logic        NMIB,
    input  logic        IRQB,
    input  logic        RDY,
    input  logic        i_flag,
    input  logic        inst_done,
    input  logic        brk,
    input  logic        wai,
    output logic        busy,
    output logic        stack_op,
    output logic        stack_wr,
    output logic [1:0]  push_sel,
    output logic        b_out,
    output logic        vec_rd,
    output logic [15:0] vec_addr,
    output logic        VPB,
    output logic        set_i,
    output logic        clr_d,
    output logic        waiting,
    output logic        wake
);

    typedef enum logic [3:0] {
        S_RST_HOLD = 4'd0,
        S_IDLE     = 4'd1,
        S_INT1     = 4'd2,
        S_INT2     = 4'd3,
        S_PUSH_H   = 4'd4,
        S_PUSH_L   = 4'd5,
        S_PUSH_P   = 4'd6,
        S_VEC_L    = 4'd7,
        S_VEC_H    = 4'd8
`ifdef INT_SEQ_WAI_EN
        ,
        S_WAIT     = 4'd9
`endif
    } state_t;

    typedef enum logic [1:0] {
        K_RESET = 2'd0,
        K_NMI   = 2'd1,
        K_BRK   = 2'd2,
        K_IRQ   = 2'd3
    } kind_t;

    state_t state;
    state_t next_state;
    kind_t  kind;
    kind_t  next_kind;

    logic nmi_s1;
    logic nmi_s2;
    logic nmi_s3;
    logic irq_s1;
    logic irq_s2;
    logic nmi_fall;
    logic nmi_pend;
    logic rst_pend;
    logic irq_req;
    logic nmi_clr;
    logic rst_clr;

    logic        busy_c;
    logic        stack_op_c;
    logic        stack_wr_c;
    logic [1:0]  push_sel_c;
    logic        b_out_c;
    logic        vec_rd_c;
    logic [15:0] vec_addr_c;
    logic        vpb_c;
    logic        set_i_c;
    logic        clr_d_c;
    logic        waiting_c;
    logic        wake_c;
    logic [15:0] vec_base_c;

    // Two-flop synchronisers plus one extra NMI stage for falling-edge detect
    always_ff @(posedge PHI2) begin
        if (RES) begin
            nmi_s1 <= 1'b1;
            nmi_s2 <= 1'b1;
            nmi_s3 <= 1'b1;
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
        end else begin
            nmi_s1 <= NMIB;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
            irq_s1 <= IRQB;
            irq_s2 <= irq_s1;
        end
    end

    assign nmi_fall = nmi_s3 & ~nmi_s2;
    assign irq_req  = ~irq_s2 & ~i_flag;

    // Pending flags drop as the matching sequence enters its vector fetch
    assign nmi_clr = RDY & (state == S_PUSH_P) & (kind == K_NMI);
    assign rst_clr = RDY & (state == S_PUSH_P) & (kind == K_RESET);

    // Pending-request latches; a fresh NMI edge wins over a same-cycle clear
    always_ff @(posedge PHI2) begin
        if (RES) begin
            nmi_pend <= 1'b0;
            rst_pend <= 1'b1;
        end else begin
            if (nmi_fall) begin
                nmi_pend <= 1'b1;
            end else if (nmi_clr) begin
                nmi_pend <= 1'b0;
            end
            if (rst_clr) begin
                rst_pend <= 1'b0;
            end
        end
    end

    // State and kind registers; RDY low freezes the sequence
    always_ff @(posedge PHI2) begin
        if (RES) begin
            state <= S_RST_HOLD;
            kind  <= K_RESET;
        end else if (RDY) begin
            state <= next_state;
            kind  <= next_kind;
        end
    end

    // Next-state and arbitration: NMI > BRK > IRQ at instruction boundaries
    always_comb begin
        next_state = state;
        next_kind  = kind;
        case (state)
            S_RST_HOLD: begin
                if (rst_pend) begin
                    next_state = S_INT1;
                    next_kind  = K_RESET;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (inst_done) begin
                    if (nmi_pend) begin
                        next_state = S_INT1;
                        next_kind  = K_NMI;
                    end else if (brk) begin
                        next_state = S_INT1;
                        next_kind  = K_BRK;
                    end else if (irq_req) begin
                        next_state = S_INT1;
                        next_kind  = K_IRQ;
                    end
`ifdef INT_SEQ_WAI_EN
                    else if (wai) begin
                        next_state = S_WAIT;
                    end
`endif
                end
            end
            S_INT1:   next_state = S_INT2;
            S_INT2:   next_state = S_PUSH_H;
            S_PUSH_H: next_state = S_PUSH_L;
            S_PUSH_L: next_state = S_PUSH_P;
            S_PUSH_P: next_state = S_VEC_L;
            S_VEC_L:  next_state = S_VEC_H;
            S_VEC_H:  next_state = S_IDLE;
`ifdef INT_SEQ_WAI_EN
            S_WAIT: begin
                if (nmi_pend) begin
                    next_state = S_INT1;
                    next_kind  = K_NMI;
                end else if (~irq_s2) begin
                    if (~i_flag) begin
                        next_state = S_INT1;
                        next_kind  = K_IRQ;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
`endif
            default:  next_state = S_IDLE;
        endcase
    end

    // Vector base for the sequence kind; BRK shares the IRQ vector
    always_comb begin
        vec_base_c = IRQ_VEC;
        case (next_kind)
            K_RESET: vec_base_c = RST_VEC;
            K_NMI:   vec_base_c = NMI_VEC;
            default: vec_base_c = IRQ_VEC;
        endcase
    end

    // Output decode from the state being entered, so outputs align with state
    always_comb begin
        busy_c     = 1'b0;
        stack_op_c = 1'b0;
        stack_wr_c = 1'b0;
        push_sel_c = 2'd0;
        b_out_c    = 1'b0;
        vec_rd_c   = 1'b0;
        vec_addr_c = 16'h0000;
        vpb_c      = 1'b1;
        set_i_c    = 1'b0;
        clr_d_c    = 1'b0;
        waiting_c  = 1'b0;
        wake_c     = 1'b0;
        case (next_state)
            S_RST_HOLD, S_INT1, S_INT2: begin
                busy_c = 1'b1;
            end
            S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
                busy_c     = 1'b1;
                stack_op_c = 1'b1;
                // Reset performs dummy stack reads instead of pushes
                stack_wr_c = (next_kind != K_RESET);
                if (next_state == S_PUSH_L) begin
                    push_sel_c = 2'd1;
                end else if (next_state == S_PUSH_P) begin
                    push_sel_c = 2'd2;
                    // B bit is only meaningful alongside the P push
                    b_out_c    = (next_kind == K_BRK);
                end
            end
            S_VEC_L: begin
                busy_c     = 1'b1;
                vec_rd_c   = 1'b1;
                vpb_c      = 1'b0;
                vec_addr_c = vec_base_c;
            end
            S_VEC_H: begin
                busy_c     = 1'b1;
                vec_rd_c   = 1'b1;
                vpb_c      = 1'b0;
                vec_addr_c = vec_base_c + 16'd1;
                set_i_c    = 1'b1;
                clr_d_c    = 1'b1;
            end
`ifdef INT_SEQ_WAI_EN
            S_WAIT: begin
                waiting_c = 1'b1;
            end
            S_IDLE: begin
                // Masked IRQ ends WAI without vectoring
                wake_c = (state == S_WAIT);
            end
`endif
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

`ifndef INT_SEQ_WAI_EN
    logic unused_wai;
    assign unused_wai = wai;
`endif

    // Output registers; RDY low holds every output, stretching pulses
    always_ff @(posedge PHI2) begin
        if (RES) begin
            busy     <= 1'b0;
            stack_op <= 1'b0;
            stack_wr <= 1'b0;
            push_sel <= 2'd0;
            b_out    <= 1'b0;
            vec_rd   <= 1'b0;
            vec_addr <= 16'h0000;
            VPB      <= 1'b1;
            set_i    <= 1'b0;
            clr_d    <= 1'b0;
            waiting  <= 1'b0;
            wake     <= 1'b0;
        end else if (RDY) begin
            busy     <= busy_c;
            stack_op <= stack_op_c;
            stack_wr <= stack_wr_c;
            push_sel <= push_sel_c;
            b_out    <= b_out_c;
            vec_rd   <= vec_rd_c;
            vec_addr <= vec_addr_c;
            VPB      <= vpb_c;
            set_i    <= set_i_c;
            clr_d    <= clr_d_c;
            waiting  <= waiting_c;
            wake     <= wake_c;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer: directed vectors, a step-count model of
// the entry sequence compared every cycle, plus literal spot checks.
// Honours INT_SEQ_WAI_EN the same way as the design.
module tb_interrupt_sequencer;

`ifdef INT_SEQ_WAI_EN
    localparam bit WAI_EN = 1'b1;
`else
    localparam bit WAI_EN = 1'b0;
`endif

    logic        PHI2;
    logic        RES;
    logic        NMIB;
    logic        IRQB;
    logic        RDY;
    logic        i_flag;
    logic        inst_done;
    logic        brk;
    logic        wai;
    logic        busy;
    logic        stack_op;
    logic        stack_wr;
    logic [1:0]  push_sel;
    logic        b_out;
    logic        vec_rd;
    logic [15:0] vec_addr;
    logic        VPB;
    logic        set_i;
    logic        clr_d;
    logic        waiting;
    logic        wake;

    int tests;
    int fails;

    interrupt_sequencer dut (
        .PHI2      (PHI2),
        .RES       (RES),
        .NMIB      (NMIB),
        .IRQB      (IRQB),
        .RDY       (RDY),
        .i_flag    (i_flag),
        .inst_done (inst_done),
        .brk       (brk),
        .wai       (wai),
        .busy      (busy),
        .stack_op  (stack_op),
        .stack_wr  (stack_wr),
        .push_sel  (push_sel),
        .b_out     (b_out),
        .vec_rd    (vec_rd),
        .vec_addr  (vec_addr),
        .VPB       (VPB),
        .set_i     (set_i),
        .clr_d     (clr_d),
        .waiting   (waiting),
        .wake      (wake)
    );

    initial PHI2 = 1'b0;
    always #5 PHI2 = ~PHI2;

    // ---------------- behavioural model ----------------
    // phase: -2 reset hold, -1 WAI halt, 0 idle, 1..7 step of entry sequence
    // kind : 0 reset, 1 NMI, 2 BRK, 3 IRQ
    int          ph;
    int          kd;
    bit          mp;
    bit [2:0]    nh;
    bit [1:0]    ih;
    bit          model_valid = 1'b0;
    logic [27:0] exp_v;

    function automatic logic [27:0] outs(input int p, input int k, input bit wk);
        logic [15:0] base;
        logic        so;
        logic        vr;
        base = (k == 1) ? 16'hFFFA : ((k == 0) ? 16'hFFFC : 16'hFFFE);
        so   = (p >= 3) && (p <= 5);
        vr   = (p >= 6) && (p <= 7);
        return {(p >= 1), so, (so && (k != 0)), (so ? 2'(p - 3) : 2'd0),
                ((p == 5) && (k == 2)), vr, (vr ? base + 16'(p - 6) : 16'h0000),
                ~vr, (p == 7), (p == 7), (p == -1), wk};
    endfunction

    always @(posedge PHI2) begin : model
        bit fall;
        bit irq_low;
        bit wk;
        int np;
        int nk;
        if (RES) begin
            ph = -2; kd = 0; mp = 1'b0; nh = 3'b111; ih = 2'b11;
            exp_v = outs(0, 0, 1'b0);
            model_valid = 1'b1;
        end else begin
            fall    = nh[2] & ~nh[1];
            irq_low = ~ih[1];
            if (RDY) begin
                np = ph; nk = kd; wk = 1'b0;
                if (ph == -2) begin
                    np = 1; nk = 0;
                end else if (ph == 0) begin
                    if (inst_done) begin
                        if (mp) begin np = 1; nk = 1; end
                        else if (brk) begin np = 1; nk = 2; end
                        else if (irq_low && !i_flag) begin np = 1; nk = 3; end
                        else if (WAI_EN && wai) np = -1;
                    end
                end else if (ph == -1) begin
                    if (mp) begin np = 1; nk = 1; end
                    else if (irq_low) begin
                        if (!i_flag) begin np = 1; nk = 3; end
                        else begin np = 0; wk = 1'b1; end
                    end
                end else if (ph == 7) begin
                    np = 0;
                end else begin
                    np = ph + 1;
                end
                if (np == 6 && nk == 1) mp = 1'b0;
                ph = np; kd = nk;
                exp_v = outs(ph, kd, wk);
            end
            if (fall) mp = 1'b1;
            nh = {nh[1:0], NMIB};
            ih = {ih[0], IRQB};
        end
    end

    // Cycle-by-cycle compare of every output against the model
    always @(negedge PHI2) begin
        logic [27:0] act;
        if (model_valid) begin
            act = {busy, stack_op, stack_wr, push_sel, b_out, vec_rd, vec_addr,
                   VPB, set_i, clr_d, waiting, wake};
            tests++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp_v);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge PHI2);
    endtask

    // One-cycle instruction boundary; returns at the negedge where INT1 shows
    task automatic fire(input logic b, input logic w);
        inst_done = 1'b1; brk = b; wai = w;
        step(1);
        inst_done = 1'b0; brk = 1'b0; wai = 1'b0;
    endtask

    // Called at the INT1 cycle (k=1); walks to the following idle cycle (k=8)
    task automatic seq_check(input string tag, input logic [15:0] base,
                             input logic exp_wr, input logic exp_b);
        chk({tag, ".busy1"}, 16'(busy), 16'd1);
        for (int k = 2; k <= 8; k++) begin
            step(1);
            if (k == 3) begin
                chk({tag, ".op3"}, 16'(stack_op), 16'd1);
                chk({tag, ".wr3"}, 16'(stack_wr), 16'(exp_wr));
            end
            if (k == 5) begin
                chk({tag, ".sel5"}, 16'(push_sel), 16'd2);
                chk({tag, ".b5"}, 16'(b_out), 16'(exp_b));
            end
            if (k == 6) begin
                chk({tag, ".vecl"}, vec_addr, base);
                chk({tag, ".vpb6"}, 16'(VPB), 16'd0);
            end
            if (k == 7) begin
                chk({tag, ".vech"}, vec_addr, base + 16'd1);
                chk({tag, ".seti"}, 16'(set_i), 16'd1);
            end
            if (k == 8) chk({tag, ".busy8"}, 16'(busy), 16'd0);
        end
    endtask

    task automatic irq_on();
        IRQB = 1'b0; i_flag = 1'b0;
        step(2);
    endtask

    task automatic irq_off();
        IRQB = 1'b1; i_flag = 1'b1;
        step(3);
    endtask

    initial begin
        tests = 0; fails = 0;
        RES = 1'b1; NMIB = 1'b1; IRQB = 1'b1; RDY = 1'b1; i_flag = 1'b1;
        inst_done = 1'b0; brk = 1'b0; wai = 1'b0;

        // Reset values, then the reset entry sequence
        step(3);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.vpb", 16'(VPB), 16'd1);
        chk("rst.addr", vec_addr, 16'h0000);
        RES = 1'b0;
        step(1);
        seq_check("reset", 16'hFFFC, 1'b0, 1'b0);
        step(2);

        // IRQ with I clear
        irq_on();
        fire(1'b0, 1'b0);
        seq_check("irq", 16'hFFFE, 1'b1, 1'b0);
        irq_off();

        // BRK while IRQ also requested: BRK wins
        irq_on();
        fire(1'b1, 1'b0);
        seq_check("brk", 16'hFFFE, 1'b1, 1'b1);
        irq_off();

        // NMI edge during an IRQ sequence is deferred to the next boundary
        irq_on();
        fire(1'b0, 1'b0);
        step(1);
        NMIB = 1'b0;
        step(4);
        chk("nmidefer.vec", vec_addr, 16'hFFFE);
        step(2);
        IRQB = 1'b1; i_flag = 1'b1;
        step(2);
        fire(1'b0, 1'b0);
        NMIB = 1'b1;
        seq_check("nmi", 16'hFFFA, 1'b1, 1'b0);
        step(1);
        fire(1'b0, 1'b0);
        chk("nmi.cleared", 16'(busy), 16'd0);
        step(2);

        // RDY low for four cycles in PUSH_L
        irq_on();
        fire(1'b0, 1'b0);
        step(3);
        chk("rdy.sel0", 16'(push_sel), 16'd1);
        RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("rdy.hold", 16'(push_sel), 16'd1);
        end
        RDY = 1'b1;
        step(1);
        chk("rdy.resume", 16'(push_sel), 16'd2);
        step(3);
        irq_off();

        // inst_done while busy is ignored; RES mid-sequence abandons it
        irq_on();
        fire(1'b0, 1'b0);
        inst_done = 1'b1;
        step(1);
        inst_done = 1'b0;
        RES = 1'b1; IRQB = 1'b1; i_flag = 1'b1;
        step(1);
        chk("midres.busy", 16'(busy), 16'd0);
        chk("midres.vpb", 16'(VPB), 16'd1);
        RES = 1'b0; RDY = 1'b0;
        step(2);
        chk("midres.frozen", 16'(busy), 16'd0);
        RDY = 1'b1;
        step(1);
        seq_check("reset2", 16'hFFFC, 1'b0, 1'b0);
        step(2);

        // WAI behaviour
        fire(1'b0, 1'b1);
        chk("wai.busy", 16'(busy), 16'd0);
        if (WAI_EN) begin
            chk("wai.waiting", 16'(waiting), 16'd1);
            IRQB = 1'b0;
            step(2);
            chk("wai.still", 16'(waiting), 16'd1);
            step(1);
            chk("wai.wake", 16'(wake), 16'd1);
            chk("wai.novec", 16'(vec_rd), 16'd0);
            chk("wai.left", 16'(waiting), 16'd0);
            step(1);
            chk("wai.wake1", 16'(wake), 16'd0);
            IRQB = 1'b1;
            step(3);
            fire(1'b0, 1'b1);
            NMIB = 1'b0;
            step(4);
            NMIB = 1'b1;
            seq_check("wai_nmi", 16'hFFFA, 1'b1, 1'b0);
        end else begin
            chk("wai.ignored", 16'(waiting), 16'd0);
        end
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
